pipe_regfile_mp: RTL and testbench
==================================

// Module: pipe_regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file for the pipelined core; replaces the fixed 32x64 2-read file.
//  Adds a hardwired-zero entry 0, write-to-read bypass on every read port, and a per-entry pending-write scoreboard.
//  Adds a post-reset init sequencer that loads every entry before the pipeline is released.
//  Sits between the decode stage (reads, issue marking) and the writeback stage (write port).
// PARAMETERS
//  DATA_W    64  entry width in bits
//  DEPTH     32  number of entries; power of two, >=4
//  NUM_RD     2  number of read ports, 1..4
//  INIT_MODE  1  value loaded by the init sweep: 0 = all zero, 1 = entry index (entry i <= i)
//  AW = $clog2(DEPTH)  derived localparam, not overridable
// PORTS
//  clk       in   1              clock, rising edge
//  reset     in   1              synchronous, active-high
//  rd_addr   in   NUM_RD*AW      read addresses, port p at [p*AW +: AW]
//  rd_data   out  NUM_RD*DATA_W  read data, port p at [p*DATA_W +: DATA_W]
//  rd_busy   out  NUM_RD         port p's entry has a write pending
//  wr_en     in   1              writeback write enable
//  wr_addr   in   AW             writeback address
//  wr_data   in   DATA_W         writeback data
//  iss_en    in   1              decode issued an instruction that will write iss_addr
//  iss_addr  in   AW             destination being marked pending
//  ready     out  1              init sweep done; file usable
// BEHAVIOUR
//  FSM: states INIT, RUN.
//  - reset high: state <= INIT, sweep counter <= 0, all busy bits <= 0, ready <= 0.
//  - INIT: one entry per cycle, mem[cnt] <= (INIT_MODE ? cnt : 0); cnt <= cnt+1.
//  - INIT -> RUN on the cycle that writes entry DEPTH-1. ready rises DEPTH cycles after reset falls.
//  - reset asserted mid-sweep, or in RUN: restarts the sweep from 0.
//  In INIT: wr_en and iss_en are ignored; rd_data = 0; rd_busy = 0.
//  Reads (RUN): combinational, zero latency.
//  - rd_data[p] = 0 if rd_addr[p]==0.
//  - else wr_data if wr_en && wr_addr==rd_addr[p] (bypass).
//  - else mem[rd_addr[p]].
//  Writes (RUN): mem[wr_addr] <= wr_data at posedge when wr_en && wr_addr!=0. Writes to entry 0 are dropped.
//  Scoreboard busy[DEPTH] (RUN):
//  - posedge: wr_en clears busy[wr_addr]; iss_en sets busy[iss_addr].
//  - Same entry in the same cycle: set wins (a new writer is in flight).
//  - busy[0] is constantly 0; iss to entry 0 is ignored.
//  - rd_busy[p] = busy[a] && !(wr_en && wr_addr==a), where a = rd_addr[p]. A bypassed write resolves the hazard.
//  - A same-cycle iss does not affect rd_busy until the next cycle.
//  Outputs after reset: ready=0, rd_data=0, rd_busy=0; dbg_data=0 when compiled in.
//  Address widths are exact; no out-of-range addresses exist because DEPTH is a power of two.
// CONFIGURATION
//  RF_DBG_TAP_EN defined:
//  - adds ports dbg_addr in AW and dbg_data out DATA_W.
//  - dbg_data = mem[dbg_addr] with no bypass, or 0 in INIT. Used for waveform/board observation.
//  RF_DBG_TAP_EN undefined: the ports are absent and no extra logic is generated.
// STRUCTURE
//  Package rf_pkg:
//  - rf_state_e enum {RF_INIT, RF_RUN}.
//  - localparams RF_INIT_ZERO=0 and RF_INIT_INDEX=1.
//  - function rf_port_sel for flattened-bus slicing.
//  Sub-module rf_init_seq: owns the sweep counter, state and ready. Outputs init_we, init_addr, init_data.
//  Top module: storage array, write mux (init vs writeback), bypass per read port (generate loop), busy vector.
// TESTING
//  1 Release reset, INIT_MODE=1, DEPTH=32 -> ready=0 for 32 cycles, then 1; entry 5 reads 5; rd_data=0 during the sweep.
//  2 wr_en, wr_addr=7, wr_data=0xDEAD with rd_addr[0]=7 in the same cycle -> rd_data[0]=0xDEAD that cycle and every later cycle.
//  3 wr_en to addr 0 with data 0xFFFF; iss_en addr 0 -> rd_data for addr 0 stays 0; rd_busy stays 0.
//  4 iss 9 at cycle t -> rd_busy=1 from t+1 on.
//  5 wb 9 at cycle t+3 -> rd_busy=0 in t+3 (bypass); busy clear at t+4.
//  6 wb 9 and iss 9 in the same cycle -> busy remains 1.
//  7 Assert reset for 1 cycle at sweep count 10 -> sweep restarts; ready rises 32 cycles after the deassert; busy all clear.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and helpers for the pipelined-core register file.
//   rf_state_e    : init sweep / normal operation
//   RF_INIT_*     : values for the INIT_MODE parameter
//   rf_port_sel   : bit offset of a port inside a flattened multi-port bus
package rf_pkg;

   typedef enum logic {
      RF_INIT = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_e;

   localparam int unsigned RF_INIT_ZERO  = 0;
   localparam int unsigned RF_INIT_INDEX = 1;

   // Offset of port 'port' in a bus built from 'width'-bit fields.
   function automatic int unsigned rf_port_sel(input int unsigned port, input int unsigned width);
      return port * width;
   endfunction

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset init sequencer: walks every entry once, then releases the file.
//   clk, reset : clock, synchronous active-high reset
//   init_we    : sweep write strobe for the current entry
//   init_addr  : entry being initialised
//   init_data  : value loaded (zero or entry index, per INIT_MODE)
//   run        : sweep finished, normal operation
//   ready      : registered "file usable" flag
module rf_init_seq
   import rf_pkg::*;
#(
   parameter  int unsigned DATA_W    = 64,
   parameter  int unsigned DEPTH     = 32,
   parameter  int unsigned INIT_MODE = 1,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   output logic              init_we,
   output logic [AW-1:0]     init_addr,
   output logic [DATA_W-1:0] init_data,
   output logic              run,
   output logic              ready
);

   rf_state_e   state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic        ready_q, ready_d;

   // Next-state: advance one entry per cycle, leave INIT on the last entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      unique case (state_q)
         RF_INIT: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = RF_RUN;
               ready_d = 1'b1;
            end
         end
         RF_RUN:  state_d = RF_RUN;
         default: state_d = RF_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RF_INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ready_q <= ready_d;
      end
   end

   // A reset cycle must not land a sweep write; the counter is being cleared.
   assign init_we   = (state_q == RF_INIT) && !reset;
   assign init_addr = cnt_q;
   assign init_data = (INIT_MODE == RF_INIT_INDEX) ? DATA_W'(cnt_q) : '0;
   assign run       = (state_q == RF_RUN);
   assign ready     = ready_q;

endmodule

// File: rtl/pipe_regfile_mp.sv
// Multi-read-port register file for the pipelined core.
// Entry 0 reads as zero, every read port bypasses the same-cycle writeback,
// and a per-entry busy scoreboard tracks issued-but-not-written destinations.
// An init sweep loads every entry after reset before 'ready' rises.
//   clk, reset : clock, synchronous active-high reset
//   rd_addr    : NUM_RD flattened read addresses (port p at [p*AW +: AW])
//   rd_data    : NUM_RD flattened read data (port p at [p*DATA_W +: DATA_W])
//   rd_busy    : per-port pending-write flag
//   wr_en/wr_addr/wr_data : writeback port
//   iss_en/iss_addr       : decode marks a destination pending
//   ready      : init sweep complete
// Build option RF_DBG_TAP_EN adds dbg_addr/dbg_data, a raw array observation port.
module pipe_regfile_mp
   import rf_pkg::*;
#(
   parameter  int unsigned DATA_W    = 64,
   parameter  int unsigned DEPTH     = 32,
   parameter  int unsigned NUM_RD    = 2,
   parameter  int unsigned INIT_MODE = 1,
   localparam int unsigned AW        = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [AW-1:0]            wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     iss_en,
   input  logic [AW-1:0]            iss_addr,
   output logic                     ready
`ifdef RF_DBG_TAP_EN
   ,
   input  logic [AW-1:0]            dbg_addr,
   output logic [DATA_W-1:0]        dbg_data
`endif
);

   logic              init_we;
   logic [AW-1:0]     init_addr;
   logic [DATA_W-1:0] init_data;
   logic              run;

   rf_init_seq #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .INIT_MODE (INIT_MODE)
   ) u_init_seq (
      .clk       (clk),
      .reset     (reset),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data),
      .run       (run),
      .ready     (ready)
   );

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   // Write mux: sweep owns the array in INIT, writeback in RUN; entry 0 never takes a writeback.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      if (init_we) begin
         mem_we    = 1'b1;
         mem_waddr = init_addr;
         mem_wdata = init_data;
      end else if (run && !reset && wr_en && (wr_addr != '0)) begin
         mem_we    = 1'b1;
         mem_waddr = wr_addr;
         mem_wdata = wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   logic [DEPTH-1:0] busy_q, busy_d;

   // Scoreboard: clear on writeback, then set on issue so a new writer wins a same-entry tie.
   always_comb begin
      busy_d = busy_q;
      if (run) begin
         if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
         end
         if (iss_en) begin
            busy_d[iss_addr] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Per-port read: zero entry, then writeback bypass, then array.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0] a;
      logic          hit;

      assign a   = rd_addr[rf_port_sel(p, AW) +: AW];
      assign hit = wr_en && (wr_addr == a);

      assign rd_data[rf_port_sel(p, DATA_W) +: DATA_W] =
         (!run || (a == '0)) ? '0 : (hit ? wr_data : mem_q[a]);

      // The bypassed write delivers the value this cycle, so the hazard is already resolved.
      assign rd_busy[p] = run && busy_q[a] && !hit;
   end

`ifdef RF_DBG_TAP_EN
   assign dbg_data = run ? mem_q[dbg_addr] : '0;
`else
   // No observation port in this build.
`endif

endmodule

// File: tb/tb_pipe_regfile_mp.sv
module tb_pipe_regfile_mp;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned DEPTH  = 32;
   localparam int unsigned NUM_RD = 2;
   localparam int unsigned AW     = 5;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_RD*AW-1:0]     rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [AW-1:0]            wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     iss_en;
   logic [AW-1:0]            iss_addr;
   logic                     ready;

   logic [AW-1:0] ra0, ra1;
   assign rd_addr = {ra1, ra0};

   pipe_regfile_mp #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .NUM_RD    (NUM_RD),
      .INIT_MODE (1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .ready    (ready)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: array contents, pending set, sweep progress.
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_busy [DEPTH];
   bit                m_ready = 1'b0;
   int                m_cnt   = 0;

   task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DATA_W-1:0] exp_data(input logic [AW-1:0] a);
      if (!m_ready || a == 0)                  return '0;
      if (wr_en && wr_addr == a)               return wr_data;
      return m_mem[a];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      return m_ready && m_busy[a] && !(wr_en && wr_addr == a);
   endfunction

   // Sample combinational outputs mid-cycle and compare with the model.
   task automatic sample();
      #2;
      chk("ready",    64'(ready),      64'(m_ready));
      chk("rd_data0", rd_data[63:0],   exp_data(ra0));
      chk("rd_data1", rd_data[127:64], exp_data(ra1));
      chk("rd_busy0", 64'(rd_busy[0]), 64'(exp_busy(ra0)));
      chk("rd_busy1", 64'(rd_busy[1]), 64'(exp_busy(ra1)));
   endtask

   task automatic model_edge();
      if (reset) begin
         m_ready = 1'b0;
         m_cnt   = 0;
         for (int i = 0; i < int'(DEPTH); i++) m_busy[i] = 1'b0;
      end else if (!m_ready) begin
         m_mem[m_cnt] = 64'(m_cnt);
         m_cnt++;
         if (m_cnt == int'(DEPTH)) m_ready = 1'b1;
      end else begin
         if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
         if (wr_en)                 m_busy[wr_addr] = 1'b0;
         if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = 1'b0; iss_en = 1'b0;
   endtask

   task automatic rand_in(input int span);
      wr_en    = 1'($urandom);
      wr_addr  = AW'($urandom_range(0, span));
      wr_data  = {$urandom, $urandom};
      iss_en   = 1'($urandom);
      iss_addr = AW'($urandom_range(0, span));
      ra0      = AW'($urandom_range(0, span));
      ra1      = AW'($urandom_range(0, span));
   endtask

   initial begin
      reset = 1'b1; idle(); wr_addr = '0; wr_data = '0; iss_addr = '0; ra0 = '0; ra1 = '0;
      @(posedge clk); model_edge(); @(negedge clk);
      sample(); tick();

      // Sweep after reset: ready low 32 cycles, reads zero, writes/issues ignored.
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rand_in(31);
         sample();
         chk("sweep_ready", 64'(ready), 64'(0));
         chk("sweep_rd0",   rd_data[63:0], 64'(0));
         tick();
      end
      idle(); ra0 = 5; ra1 = 31;
      sample();
      chk("ready_up", 64'(ready), 64'(1));
      chk("entry5",   rd_data[63:0], 64'd5);
      chk("entry31",  rd_data[127:64], 64'd31);
      tick();

      // Write with same-cycle read: bypass, then stored.
      wr_en = 1'b1; wr_addr = 7; wr_data = 64'hDEAD; ra0 = 7;
      sample(); chk("byp7", rd_data[63:0], 64'hDEAD); tick();
      idle();
      for (int i = 0; i < 2; i++) begin
         sample(); chk("held7", rd_data[63:0], 64'hDEAD); tick();
      end

      // Entry 0 ignores writes and issues.
      wr_en = 1'b1; wr_addr = 0; wr_data = 64'hFFFF; iss_en = 1'b1; iss_addr = 0; ra0 = 0;
      sample(); chk("z_data", rd_data[63:0], 64'h0); chk("z_busy", 64'(rd_busy[0]), 64'(0)); tick();
      idle();
      sample(); chk("z_data2", rd_data[63:0], 64'h0); chk("z_busy2", 64'(rd_busy[0]), 64'(0)); tick();

      // Issue 9 at t, writeback at t+3.
      ra0 = 9; iss_en = 1'b1; iss_addr = 9;
      sample(); chk("iss_t0", 64'(rd_busy[0]), 64'(0)); tick();
      idle();
      sample(); chk("iss_t1", 64'(rd_busy[0]), 64'(1)); tick();
      sample(); chk("iss_t2", 64'(rd_busy[0]), 64'(1)); tick();
      wr_en = 1'b1; wr_addr = 9; wr_data = 64'h1234_5678;
      sample(); chk("wb_t3_busy", 64'(rd_busy[0]), 64'(0)); chk("wb_t3_data", rd_data[63:0], 64'h1234_5678); tick();
      idle();
      sample(); chk("wb_t4_busy", 64'(rd_busy[0]), 64'(0)); chk("wb_t4_data", rd_data[63:0], 64'h1234_5678); tick();

      // Same-cycle writeback and reissue: set wins.
      iss_en = 1'b1; iss_addr = 9; tick();
      iss_en = 1'b1; wr_en = 1'b1; wr_addr = 9; wr_data = 64'hABCD;
      sample(); chk("tie_byp", 64'(rd_busy[0]), 64'(0)); tick();
      idle();
      sample(); chk("tie_busy", 64'(rd_busy[0]), 64'(1)); tick();
      wr_en = 1'b1; wr_data = 64'h55; tick(); idle();

      // Randomised traffic concentrated on a few entries, rare resets.
      for (int i = 0; i < 400; i++) begin
         rand_in(($urandom % 4 == 0) ? 31 : 7);
         reset = ($urandom % 150 == 0);
         sample();
         tick();
      end
      reset = 1'b0; idle();
      for (int i = 0; i < 40 && !m_ready; i++) begin sample(); tick(); end

      // Reset mid-sweep restarts the sweep and clears the scoreboard.
      iss_en = 1'b1; iss_addr = 12; tick(); idle();
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 10; i++) begin sample(); tick(); end
      reset = 1'b1; tick(); reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         sample(); chk("restart_ready", 64'(ready), 64'(0)); tick();
      end
      ra0 = 12;
      sample();
      chk("restart_up",   64'(ready), 64'(1));
      chk("restart_busy", 64'(rd_busy[0]), 64'(0));
      chk("restart_data", rd_data[63:0], 64'd12);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
